spi_flash_reader: RTL and testbench

Services 6809 read cycles that the address decoder routes to SPI flash (CPU window 0xF000–0xFFFF, active-low `i_spi_ce`). For each access it issues a serial READ (0x03) transaction to the flash, stalls the CPU via MRDY until the byte arrives, and presents that byte on the data bus. It yields the flash pins whenever the FT2232 holds its active-low chip select.

---
 rtl/spi_flash_reader.sv | 160 ++++++++++++++++
 tb/tb_spi_flash_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// Services 6809 reads in the 0xF000-0xFFFF window with a serial READ (0x03) to SPI flash.
// Stalls the CPU through MRDY until the byte arrives and yields the flash pins to the FT2232.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter logic [7:0]  READ_CMD   = 8'h03
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_spi_ce,
  input  logic        i_rw,
  input  logic [15:0] i_address,
  input  logic        i_FT_CS,
  output logic [7:0]  o_data,
  output logic        o_mrdy,
  output logic        o_spi_oe,
  output logic        o_spi_cs_n,
  output logic        o_spi_sck,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);

  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_MAX = 2 * CLK_DIV - 1;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);
  localparam int unsigned BIT_W   = 6;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [31:0]        tx_q, tx_d;
  logic [7:0]         rx_q, rx_d;
  logic [7:0]         data_q, data_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               cs_n_q, cs_n_d;
  logic               oe_q, oe_d;

  logic        req;
  logic [23:0] flash_addr;
  logic        unused_addr_hi;

  assign req            = ~i_spi_ce & i_rw;
  assign flash_addr     = FLASH_BASE + {12'h000, i_address[11:0]};
  assign unused_addr_hi = ^i_address[15:12];

  // CPU waits for any pending read until the byte is on the bus
  assign o_mrdy     = i_reset | ~(req & (state_q != S_DONE));
  assign o_data     = data_q;
  assign o_spi_oe   = oe_q;
  assign o_spi_cs_n = cs_n_q;
  assign o_spi_sck  = sck_q;
  assign o_spi_mosi = mosi_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= GAP_W'(GAP_MAX);
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      oe_q    <= oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    oe_d    = oe_q;

    // Counts CS-high cycles so back-to-back accesses honour the flash deselect time
    if (!cs_n_q)                        gap_d = '0;
    else if (gap_q != GAP_W'(GAP_MAX))  gap_d = gap_q + 1'b1;
    else                                gap_d = gap_q;

    case (state_q)
      S_IDLE: begin
        if (req && i_FT_CS && (gap_q == GAP_W'(GAP_MAX))) begin
          state_d = S_CMD;
          cs_n_d  = 1'b0;
          oe_d    = 1'b1;
          sck_d   = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          tx_d    = {READ_CMD, flash_addr};
          mosi_d  = READ_CMD[7];
        end
      end
      S_CMD, S_ADDR, S_DATA: begin
        if (!req || !i_FT_CS) begin
          state_d = S_IDLE;
          cs_n_d  = 1'b1;
          oe_d    = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end else if (div_q != DIV_W'(CLK_DIV - 1)) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
            rx_d  = {rx_q[6:0], i_spi_miso};
          end else begin
            // Falling SCK closes the bit; MOSI advances only here
            sck_d  = 1'b0;
            bit_d  = bit_q + 1'b1;
            tx_d   = {tx_q[30:0], 1'b0};
            mosi_d = tx_q[30];
            if (bit_q == BIT_W'(39)) begin
              state_d = S_DONE;
              cs_n_d  = 1'b1;
              oe_d    = 1'b0;
              mosi_d  = 1'b0;
              bit_d   = '0;
              data_d  = rx_q;
            end else if (bit_q == BIT_W'(7)) begin
              state_d = S_ADDR;
            end else if (bit_q == BIT_W'(31)) begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DONE: begin
        if (i_spi_ce) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (base 0 and base 0xFFFF00) against a behavioural
// SPI flash and a reference of expected command headers, data bytes and stall lengths.
module tb_spi_flash_reader;

  localparam int unsigned D     = 2;
  localparam int          STALL = 80 * D + 1;

  logic        clk;
  logic        rst;
  logic        spi_ce;
  logic        rw;
  logic [15:0] address;
  logic        ft_cs;
  logic [1:0][7:0] data;
  logic [1:0]  mrdy, oe, cs_n, sck, mosi;

  int n_cmp;
  int n_err;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h87;
  endfunction

  function automatic logic [23:0] exp_addr(input int g, input logic [15:0] a);
    logic [23:0] base;
    base = (g == 0) ? 24'h000000 : 24'hFFFF00;
    return 24'(base + {12'h000, a[11:0]});
  endfunction

  genvar g;
  for (g = 0; g < 2; g++) begin : g_dut
    localparam logic [23:0] BASE = (g == 0) ? 24'h000000 : 24'hFFFF00;
    logic        miso_g;
    int          cnt;
    int          falls;
    int          viol;
    logic [31:0] hdr;
    logic [7:0]  rd_byte;
    logic [31:0] hq[$];
    logic        psck, pmosi;

    spi_flash_reader #(.CLK_DIV(D), .FLASH_BASE(BASE), .READ_CMD(8'h03)) u_dut (
      .i_clk(clk), .i_reset(rst), .i_spi_ce(spi_ce), .i_rw(rw), .i_address(address),
      .i_FT_CS(ft_cs), .o_data(data[g]), .o_mrdy(mrdy[g]), .o_spi_oe(oe[g]),
      .o_spi_cs_n(cs_n[g]), .o_spi_sck(sck[g]), .o_spi_mosi(mosi[g]), .i_spi_miso(miso_g)
    );

    initial begin
      cnt = 0; falls = 0; viol = 0; hdr = '0; rd_byte = '0; miso_g = 1'b0;
      psck = 1'b0; pmosi = 1'b0;
    end

    // Flash model: mode 0, captures 32 header bits, then returns the addressed byte
    always @(negedge cs_n[g]) begin
      cnt = 0;
      hdr = '0;
      falls++;
    end
    always @(posedge sck[g]) begin
      if (cs_n[g] == 1'b0) begin
        if (cnt < 32) hdr = {hdr[30:0], mosi[g]};
        cnt++;
        if (cnt == 32) begin
          hq.push_back(hdr);
          rd_byte = flash_byte(hdr[23:0]);
        end
      end
    end
    always @(negedge sck[g]) begin
      if (cs_n[g] == 1'b0 && cnt >= 32 && cnt < 40) miso_g = rd_byte[3'(39 - cnt)];
    end

    // MOSI must not move while SCK stays high
    always @(posedge clk) begin
      #1;
      if (psck && sck[g] && (mosi[g] !== pmosi)) viol++;
      psck  = sck[g];
      pmosi = mosi[g];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mrdy(output int n);
    #1;
    n = 0;
    while (mrdy[0] !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic read_stall(input logic [15:0] a, output int n);
    address = a;
    rw      = 1'b1;
    spi_ce  = 1'b0;
    wait_mrdy(n);
  endtask

  task automatic pop_hdr(input string tag, input logic [15:0] a);
    logic [31:0] h0, h1;
    h0 = '1;
    h1 = '1;
    if (g_dut[0].hq.size() > 0) h0 = g_dut[0].hq.pop_front();
    if (g_dut[1].hq.size() > 0) h1 = g_dut[1].hq.pop_front();
    check_eq({tag, "_hdr0"}, h0, {8'h03, exp_addr(0, a)});
    check_eq({tag, "_hdr1"}, h1, {8'h03, exp_addr(1, a)});
  endtask

  task automatic verify(input string tag, input logic [15:0] a);
    pop_hdr(tag, a);
    check_eq({tag, "_dat0"}, 32'(data[0]), 32'(flash_byte(exp_addr(0, a))));
    check_eq({tag, "_dat1"}, 32'(data[1]), 32'(flash_byte(exp_addr(1, a))));
    check_eq({tag, "_pins"}, 32'({cs_n, oe, mrdy}), 32'(6'b11_00_11));
  endtask

  task automatic release_bus(input int cycles);
    spi_ce = 1'b1;
    repeat (cycles) tick();
  endtask

  initial begin
    int n;
    int f0;
    int bad;
    logic [15:0] a;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; spi_ce = 1'b1; rw = 1'b1; address = 16'h0000; ft_cs = 1'b1;
    repeat (3) tick();
    check_eq("rst_pins", 32'({cs_n, sck, oe, mrdy}), 32'(8'hC3));
    check_eq("rst_data", 32'({data[1], data[0]}), 32'h0);
    rst = 1'b0;
    repeat (3) tick();

    // Basic read; instance 1 exercises the wrapping base
    read_stall(16'hF123, n);
    check_eq("basic_stall", n, STALL);
    check_eq("basic_byte", 32'(data[0]), 32'h0000_00A5);
    verify("basic", 16'hF123);
    release_bus(8);

    for (int i = 0; i < 8; i++) begin
      a = 16'hF000 | 16'($urandom_range(0, 4095));
      read_stall(a, n);
      check_eq($sformatf("rnd%0d_stall", i), n, STALL);
      verify($sformatf("rnd%0d", i), a);
      release_bus(6 + int'($urandom_range(0, 6)));
    end

    // Writes are ignored
    f0 = g_dut[0].falls;
    bad = 0;
    address = 16'hF000; rw = 1'b0; spi_ce = 1'b0;
    repeat (60) begin
      tick();
      if (mrdy !== 2'b11 || cs_n !== 2'b11 || oe !== 2'b00) bad++;
    end
    check_eq("write_pins", bad, 0);
    check_eq("write_nocs", g_dut[0].falls - f0, 0);
    rw = 1'b1;
    release_bus(4);

    // FT2232 grabs the flash during ADDR bit 10
    a = 16'hF3C7;
    address = a; rw = 1'b1; spi_ce = 1'b0;
    repeat (74) tick();
    ft_cs = 1'b0;
    tick();
    check_eq("arb_abort", 32'({cs_n, oe, sck, mrdy}), 32'(8'hC0));
    check_eq("arb_nohdr", g_dut[0].hq.size(), 0);
    repeat (20) tick();
    check_eq("arb_hold", 32'({cs_n, oe, mrdy}), 32'(6'b11_00_00));
    ft_cs = 1'b1;
    wait_mrdy(n);
    check_eq("arb_resume", n, STALL);
    verify("arb", a);
    release_bus(8);

    // Holding the select low never re-triggers; a one-cycle release does, once
    f0 = g_dut[0].falls;
    a = 16'hFABC;
    read_stall(a, n);
    repeat (500) tick();
    check_eq("nr_one", g_dut[0].falls - f0, 1);
    verify("nr1", a);
    a = 16'hF5E1;
    address = a;
    spi_ce = 1'b1;
    tick();
    spi_ce = 1'b0;
    wait_mrdy(n);
    check_eq("nr2_done", 32'(n < 2000), 32'h1);
    repeat (50) tick();
    check_eq("nr_two", g_dut[0].falls - f0, 2);
    verify("nr2", a);
    release_bus(8);

    // Asynchronous reset in the DATA phase
    a = 16'hF0F0;
    address = a; rw = 1'b1; spi_ce = 1'b0;
    repeat (140) tick();
    rst = 1'b1;
    #1;
    check_eq("rstmid_pins", 32'({cs_n, sck, oe, mrdy}), 32'(8'hC3));
    check_eq("rstmid_data", 32'({data[1], data[0]}), 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    wait_mrdy(n);
    check_eq("rstmid_restart", n, STALL);
    pop_hdr("rstab", a);
    verify("rstre", a);
    release_bus(8);

    check_eq("mosi_stable0", g_dut[0].viol, 0);
    check_eq("mosi_stable1", g_dut[1].viol, 0);
    check_eq("hq_empty", g_dut[0].hq.size() + g_dut[1].hq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
